// File: rtl/kf8288_bus_arbiter.sv
// rtl/kf8288_bus_arbiter.sv - bus-ownership arbiter in front of the KF8288 bus controller
//
// Shares the system bus between the CPU and two alternate masters: DMA (high
// priority) and an external master (low priority, bounded grant length).
// Ownership only changes hands from a passive, unlocked CPU cycle, and every
// hand-over is bracketed by a settle window in which address_enable_n is high
// while no grant is active.
//
// Ports:
//   clock             system clock, rising edge
//   reset_n           asynchronous active-low reset
//   processor_status  CPU S2..S0 (3'b111 = passive)
//   lock_n            CPU bus lock, 0 blocks leaving CPU ownership
//   dma_request       DMA hold request (level)
//   ext_request       external master request (level)
//   dma_grant         DMA owns the bus
//   ext_grant         external master owns the bus
//   address_enable_n  to KF8288 AEN_n, 1 floats the CPU commands
//   cpu_wait          stretches CPU cycles while the CPU is not the owner
//   bus_owner         00 CPU, 01 DMA, 10 external, 11 in transition
//   ext_timeout       one-cycle pulse when the external grant hits its limit
module kf8288_bus_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned EXT_MAX_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] processor_status,
  input  logic       lock_n,
  input  logic       dma_request,
  input  logic       ext_request,
  output logic       dma_grant,
  output logic       ext_grant,
  output logic       address_enable_n,
  output logic       cpu_wait,
  output logic [1:0] bus_owner,
  output logic       ext_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] EXT_MAX     = 8'(EXT_MAX_CYCLES);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;          // 0 DMA, 1 external
  logic [3:0] settle_q, settle_d;
  logic [7:0] grant_cnt_q, grant_cnt_d;
  logic       dma_grant_q, dma_grant_d;
  logic       ext_grant_q, ext_grant_d;
  logic       aen_q, aen_d;
  logic [1:0] bus_owner_q, bus_owner_d;
  logic       ext_timeout_q, ext_timeout_d;
  logic       req_latched;
  logic       arb_ok;

  // Request of whichever master was latched at arbitration time.
  assign req_latched = owner_q ? ext_request : dma_request;
  assign arb_ok      = (dma_request | ext_request) & (processor_status == 3'b111) & lock_n;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    settle_d      = settle_q;
    grant_cnt_d   = grant_cnt_q;
    ext_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_ok) begin
          state_d  = ST_RELEASE;
          owner_d  = ~dma_request;   // DMA wins ties
          settle_d = SETTLE_LOAD;
        end
      end
      ST_RELEASE: begin
        if (!req_latched) begin
          state_d  = ST_RETURN;
          settle_d = SETTLE_LOAD;
        end else if (settle_q == 4'd0) begin
          state_d     = ST_GRANT;
          grant_cnt_d = 8'd1;        // first grant cycle
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_GRANT: begin
        // The limit revokes an external grant even if its request is still high.
        if (owner_q && (grant_cnt_q == EXT_MAX)) begin
          state_d       = ST_RETURN;
          settle_d      = SETTLE_LOAD;
          grant_cnt_d   = 8'd0;
          ext_timeout_d = 1'b1;
        end else if (!req_latched) begin
          state_d     = ST_RETURN;
          settle_d    = SETTLE_LOAD;
          grant_cnt_d = 8'd0;
        end else if (owner_q) begin
          grant_cnt_d = grant_cnt_q + 8'd1;
        end
      end
      ST_RETURN: begin
        if (settle_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered and decoded from the next state.
    aen_d       = (state_d != ST_IDLE);
    dma_grant_d = (state_d == ST_GRANT) & ~owner_d;
    ext_grant_d = (state_d == ST_GRANT) & owner_d;
    case (state_d)
      ST_IDLE:  bus_owner_d = 2'b00;
      ST_GRANT: bus_owner_d = owner_d ? 2'b10 : 2'b01;
      default:  bus_owner_d = 2'b11;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      settle_q      <= 4'd0;
      grant_cnt_q   <= 8'd0;
      dma_grant_q   <= 1'b0;
      ext_grant_q   <= 1'b0;
      aen_q         <= 1'b0;
      bus_owner_q   <= 2'b00;
      ext_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      settle_q      <= settle_d;
      grant_cnt_q   <= grant_cnt_d;
      dma_grant_q   <= dma_grant_d;
      ext_grant_q   <= ext_grant_d;
      aen_q         <= aen_d;
      bus_owner_q   <= bus_owner_d;
      ext_timeout_q <= ext_timeout_d;
    end
  end

  assign dma_grant        = dma_grant_q;
  assign ext_grant        = ext_grant_q;
  assign address_enable_n = aen_q;
  assign cpu_wait         = aen_q;
  assign bus_owner        = bus_owner_q;
  assign ext_timeout      = ext_timeout_q;

endmodule
